// File: rtl/ahim_pio_rx.sv
// rtl/ahim_pio_rx.sv - HPS toggle-handshake PIO receiver writing packages into breakpoint/image RAM
module ahim_pio_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int WD_DEPTH   = 20
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic                  select_mode,
  input  logic [CNT_WIDTH-1:0]  expected_packages,
  input  logic [WD_DEPTH-1:0]   watchdog_rx_conf,
  input  logic                  pio_req,
  input  logic [DATA_WIDTH-1:0] pio_data,
  output logic                  pio_ack,
  output logic                  bp_we,
  output logic                  img_we,
  output logic [CNT_WIDTH-1:0]  mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rx_done,
  output logic                  watchdog_rx_trigger,
  output logic                  rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PKG,
    S_WRITE,
    S_DONE,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic                  r_s1;
  logic                  r_s2;
  logic                  r_req_last;
  logic [DATA_WIDTH-1:0] r_pio_data;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_expected;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [WD_DEPTH-1:0]   r_wd_cnt;

  logic w_edge;
  logic w_wd_hit;

  assign w_edge   = (r_s2 != r_req_last);
  assign w_wd_hit = (watchdog_rx_conf != '0) && (r_wd_cnt == watchdog_rx_conf);

  // Strobe, address, data and ack are all registered on the edge that enters WRITE,
  // so the strobe is high exactly during the WRITE cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_IDLE;
      r_s1                <= 1'b0;
      r_s2                <= 1'b0;
      r_req_last          <= 1'b0;
      r_pio_data          <= '0;
      r_mode              <= 1'b0;
      r_expected          <= '0;
      r_count             <= '0;
      r_wd_cnt            <= '0;
      pio_ack             <= 1'b0;
      bp_we               <= 1'b0;
      img_we              <= 1'b0;
      mem_waddr           <= '0;
      mem_wdata           <= '0;
      rx_done             <= 1'b0;
      watchdog_rx_trigger <= 1'b0;
      rx_busy             <= 1'b0;
    end else begin
      r_s1                <= pio_req;
      r_s2                <= r_s1;
      r_pio_data          <= pio_data;
      bp_we               <= 1'b0;
      img_we              <= 1'b0;
      rx_done             <= 1'b0;
      watchdog_rx_trigger <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_last <= r_s2;
          if (rx_en) begin
            r_mode     <= select_mode;
            r_expected <= expected_packages;
            r_count    <= '0;
            r_wd_cnt   <= '0;
            if (expected_packages == '0) begin
              r_state <= S_DONE;
              rx_done <= 1'b1;
            end else begin
              r_state <= S_WAIT_PKG;
              rx_busy <= 1'b1;
            end
          end
        end
        S_WAIT_PKG: begin
          if (!rx_en) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end else if (w_edge) begin
            r_req_last <= r_s2;
            r_state    <= S_WRITE;
            bp_we      <= ~r_mode;
            img_we     <= r_mode;
            mem_waddr  <= r_count;
            mem_wdata  <= r_pio_data;
            pio_ack    <= ~pio_ack;
            r_count    <= r_count + 1'b1;
          end else if (w_wd_hit) begin
            r_state             <= S_HOLD;
            watchdog_rx_trigger <= 1'b1;
            rx_busy             <= 1'b0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (!rx_en) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end else if (r_count == r_expected) begin
            r_state <= S_DONE;
            rx_done <= 1'b1;
            rx_busy <= 1'b0;
          end else begin
            r_state  <= S_WAIT_PKG;
            r_wd_cnt <= '0;
          end
        end
        S_DONE, S_HOLD: begin
          if (!rx_en) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahim_pio_rx.sv
// tb/tb_ahim_pio_rx.sv - directed self-checking bench for ahim_pio_rx
module tb_ahim_pio_rx;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        rx_en;
  logic        select_mode;
  logic [15:0] expected_packages;
  logic [19:0] watchdog_rx_conf;
  logic        pio_req;
  logic [31:0] pio_data;
  logic        pio_ack;
  logic        bp_we;
  logic        img_we;
  logic [15:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        rx_done;
  logic        watchdog_rx_trigger;
  logic        rx_busy;

  ahim_pio_rx dut (
    .clk_in              (clk_in),
    .rst_n               (rst_n),
    .rx_en               (rx_en),
    .select_mode         (select_mode),
    .expected_packages   (expected_packages),
    .watchdog_rx_conf    (watchdog_rx_conf),
    .pio_req             (pio_req),
    .pio_data            (pio_data),
    .pio_ack             (pio_ack),
    .bp_we               (bp_we),
    .img_we              (img_we),
    .mem_waddr           (mem_waddr),
    .mem_wdata           (mem_wdata),
    .rx_done             (rx_done),
    .watchdog_rx_trigger (watchdog_rx_trigger),
    .rx_busy             (rx_busy)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Write/pulse log gathered on falling edges
  int          n_wr, n_img, n_done, n_trig, n_wide;
  logic        wr_kind [0:31];
  logic [15:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  logic        prev_we, prev_done, prev_trig;

  task automatic clear_mon();
    n_wr = 0; n_img = 0; n_done = 0; n_trig = 0;
  endtask

  initial begin
    n_wide = 0; prev_we = 0; prev_done = 0; prev_trig = 0;
    clear_mon();
  end

  always @(negedge clk_in) begin
    if (bp_we || img_we) begin
      if (n_wr < 32) begin
        wr_kind[n_wr] = img_we;
        wr_addr[n_wr] = mem_waddr;
        wr_data[n_wr] = mem_wdata;
      end
      n_wr++;
      if (img_we) n_img++;
    end
    if (rx_done) n_done++;
    if (watchdog_rx_trigger) n_trig++;
    if ((prev_we && (bp_we || img_we)) || (prev_done && rx_done) || (prev_trig && watchdog_rx_trigger) || (bp_we && img_we))
      n_wide++;
    prev_we   = bp_we || img_we;
    prev_done = rx_done;
    prev_trig = watchdog_rx_trigger;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    logic old;
    int   n;
    old = pio_ack;
    pio_data = d;
    pio_req = ~pio_req;
    n = 0;
    while (pio_ack === old && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("ack_toggle", {31'd0, pio_ack !== old}, 32'd1);
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    logic old_ack;
    int   n;
    rst_n = 1'b0; rx_en = 1'b0; select_mode = 1'b0; expected_packages = '0;
    watchdog_rx_conf = '0; pio_req = 1'b0; pio_data = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_ack",  {31'd0, pio_ack}, 0);
    chk("rst_we",   {30'd0, bp_we, img_we}, 0);
    chk("rst_addr", {16'd0, mem_waddr}, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_puls", {29'd0, rx_done, watchdog_rx_trigger, rx_busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Mode 0, three packages, with exact 3-edge latency on the first
    watchdog_rx_conf = 20'd100; expected_packages = 16'd3; select_mode = 1'b0; rx_en = 1'b1;
    @(negedge clk_in);
    chk("busy_wait", {31'd0, rx_busy}, 1);
    clear_mon();
    pio_data = 32'hA; pio_req = ~pio_req;
    repeat (2) @(negedge clk_in);
    chk("lat_early", {31'd0, bp_we}, 0);
    @(negedge clk_in);
    chk("lat_bpwe",  {31'd0, bp_we}, 1);
    chk("lat_addr",  {16'd0, mem_waddr}, 0);
    chk("lat_data",  mem_wdata, 32'hA);
    chk("lat_ack",   {31'd0, pio_ack}, 1);
    repeat (2) @(negedge clk_in);
    send(32'hB);
    send(32'hC);
    repeat (2) @(negedge clk_in);
    chk("m0_nwr",  n_wr, 3);
    chk("m0_a1",   {16'd0, wr_addr[1]}, 1);
    chk("m0_d1",   wr_data[1], 32'hB);
    chk("m0_a2",   {16'd0, wr_addr[2]}, 2);
    chk("m0_d2",   wr_data[2], 32'hC);
    chk("m0_img",  n_img, 0);
    chk("m0_done", n_done, 1);
    chk("m0_ack",  {31'd0, pio_ack}, 1);
    chk("m0_busy", {31'd0, rx_busy}, 0);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // Back-to-back breakpoint then strip, one-cycle rx_en gap
    clear_mon();
    expected_packages = 16'd1; select_mode = 1'b0; rx_en = 1'b1;
    @(negedge clk_in);
    send(32'h11);
    rx_en = 1'b0;
    @(negedge clk_in);
    expected_packages = 16'd2; select_mode = 1'b1; rx_en = 1'b1;
    @(negedge clk_in);
    send(32'h22);
    send(32'h33);
    repeat (2) @(negedge clk_in);
    chk("b2b_nwr",  n_wr, 3);
    chk("b2b_k",    {29'd0, wr_kind[0], wr_kind[1], wr_kind[2]}, 3'b011);
    chk("b2b_a",    {26'd0, wr_addr[0][1:0], wr_addr[1][1:0], wr_addr[2][1:0]}, 6'b00_00_01);
    chk("b2b_d2",   wr_data[2], 32'h33);
    chk("b2b_done", n_done, 2);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // Watchdog: conf=5, one package of two
    clear_mon();
    watchdog_rx_conf = 20'd5; expected_packages = 16'd2; select_mode = 1'b0; rx_en = 1'b1;
    @(negedge clk_in);
    old_ack = pio_ack;
    pio_data = 32'h77; pio_req = ~pio_req;
    n = 0;
    while (pio_ack === old_ack && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    chk("wd_lat", n, 3);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_in);
      if (i == 6) chk("wd_pre",  {31'd0, watchdog_rx_trigger}, 0);
      if (i == 7) chk("wd_trig", {31'd0, watchdog_rx_trigger}, 1);
      if (i == 8) chk("wd_post", {31'd0, watchdog_rx_trigger}, 0);
    end
    chk("wd_busy", {31'd0, rx_busy}, 0);
    pio_data = 32'h78; pio_req = ~pio_req;
    repeat (6) @(negedge clk_in);
    chk("wd_hold_nwr", n_wr, 1);
    chk("wd_ntrig",    n_trig, 1);
    chk("wd_ndone",    n_done, 0);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // Stale toggle while idle is ignored
    clear_mon();
    watchdog_rx_conf = '0;
    pio_req = ~pio_req;
    repeat (5) @(negedge clk_in);
    old_ack = pio_ack;
    expected_packages = 16'd1; select_mode = 1'b0; rx_en = 1'b1;
    repeat (6) @(negedge clk_in);
    chk("stale_nwr", n_wr, 0);
    chk("stale_ack", {31'd0, pio_ack}, {31'd0, old_ack});
    send(32'h44);
    chk("fresh_nwr",  n_wr, 1);
    chk("fresh_d",    wr_data[0], 32'h44);
    chk("fresh_done", n_done, 1);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // expected=0 completes immediately
    clear_mon();
    expected_packages = 16'd0; rx_en = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("zero_done", n_done, 1);
    chk("zero_nwr",  n_wr, 0);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // Abort after 1 of 4, then restart at address 0
    clear_mon();
    expected_packages = 16'd4; rx_en = 1'b1;
    @(negedge clk_in);
    send(32'h55);
    rx_en = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("abort_nwr",  n_wr, 1);
    chk("abort_done", n_done, 0);
    chk("abort_busy", {31'd0, rx_busy}, 0);
    expected_packages = 16'd1; rx_en = 1'b1;
    @(negedge clk_in);
    send(32'h66);
    chk("restart_a", {16'd0, wr_addr[1]}, 0);
    chk("restart_d", wr_data[1], 32'h66);
    rx_en = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset during WRITE
    expected_packages = 16'd3; rx_en = 1'b1;
    @(negedge clk_in);
    pio_data = 32'h99; pio_req = ~pio_req;
    n = 0;
    while (!bp_we && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    chk("rw_inwrite", {31'd0, bp_we}, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_we",   {30'd0, bp_we, img_we}, 0);
    chk("rw_ack",  {31'd0, pio_ack}, 0);
    chk("rw_puls", {29'd0, rx_done, watchdog_rx_trigger, rx_busy}, 0);
    chk("rw_addr", {16'd0, mem_waddr}, 0);
    rx_en = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk_in);
    chk("rw_post_nwr",  n_wr, 0);
    chk("rw_post_done", n_done + n_trig, 0);
    chk("pulse_width",  n_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahim_pio_rx.md
AHIM_PIO_RX -- requirements
Module: ahim_pio_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one PIO package and of the memory write data.
REQ-002 Parameter CNT_WIDTH, default 16: width of the package count and write address.
REQ-003 Parameter WD_DEPTH, default 20: width of the watchdog configuration and counter.
REQ-004 Port clk_in, in, 1: the only clock; all logic is on its rising edge.
REQ-005 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-006 Port rx_en, in, 1: level; a transfer is active while high.
REQ-007 Port select_mode, in, 1: 0 = breakpoint packages, 1 = strip pixel packages.
REQ-008 Port expected_packages, in, CNT_WIDTH: number of packages in the transfer.
REQ-009 Port watchdog_rx_conf, in, WD_DEPTH: idle-cycle limit between packages; 0 disables the watchdog.
REQ-010 Port pio_req, in, 1: HPS toggle; each change announces a new package.
REQ-011 Port pio_data, in, DATA_WIDTH: package word, held stable by the HPS until pio_ack toggles.
REQ-012 Port pio_ack, out, 1: toggles once per accepted package.
REQ-013 Port bp_we, out, 1: one-cycle write strobe to the breakpoint RAM.
REQ-014 Port img_we, out, 1: one-cycle write strobe to the image RAM.
REQ-015 Port mem_waddr, out, CNT_WIDTH: write address, valid while a strobe is high.
REQ-016 Port mem_wdata, out, DATA_WIDTH: write data, valid while a strobe is high.
REQ-017 Port rx_done, out, 1: one-cycle pulse when all expected packages are written.
REQ-018 Port watchdog_rx_trigger, out, 1: one-cycle pulse when the watchdog expires.
REQ-019 Port rx_busy, out, 1: high in WAIT_PKG and WRITE.

Function
REQ-020 pio_req SHALL pass through a 2-flop synchronizer (s1, s2); an edge is s2 != req_last.
REQ-021 States SHALL be IDLE, WAIT_PKG, WRITE, DONE, HOLD.
REQ-022 IDLE SHALL track req_last <= s2 every cycle, so toggles seen in IDLE are never consumed.
REQ-023 IDLE with rx_en=1 SHALL latch select_mode and expected_packages, clear count, and go to WAIT_PKG.
  - If latched expected_packages is 0, the next state SHALL be DONE instead.
REQ-024 WAIT_PKG on an edge SHALL capture the data word and req_last <= s2, then go to WRITE.
  - The data word is pio_data registered alongside s2.
REQ-025 WRITE SHALL behave as follows for exactly one cycle:
  - Assert bp_we (latched mode 0) or img_we (latched mode 1).
  - Drive mem_waddr = count and toggle pio_ack.
  - Increment count (CNT_WIDTH, no wrap).
  - Next state: DONE if count+1 == latched expected_packages, else WAIT_PKG.
REQ-026 Input-to-strobe latency SHALL be 3 rising edges after pio_req first changes at a sampling edge.
REQ-027 DONE entry SHALL pulse rx_done for one cycle; DONE holds until rx_en=0, then goes to IDLE.
REQ-028 The watchdog counter SHALL clear on entry to WAIT_PKG and increment each cycle in WAIT_PKG.
REQ-029 When counter == watchdog_rx_conf != 0 with no edge that cycle, the block SHALL:
  - Pulse watchdog_rx_trigger for one cycle.
  - Go to HOLD.
REQ-030 If an edge and a watchdog match occur in the same cycle, the package SHALL win: no trigger.
REQ-031 HOLD SHALL issue no writes and SHALL return to IDLE when rx_en=0.
REQ-032 rx_en=0 in WAIT_PKG or WRITE SHALL abort to IDLE next cycle:
  - Any WRITE-cycle strobe already in progress completes; no further strobes.
  - No rx_done and no trigger.
REQ-033 rx_en=1 in IDLE SHALL start a new transfer one cycle after a previous DONE/HOLD exit.
  - This supports breakpoint-then-strip sequencing with a one-cycle rx_en gap.
REQ-034 Outputs SHALL be registered; strobes and pulses SHALL never exceed one cycle.

Reset
REQ-035 When rst_n=0, the block SHALL go to IDLE and clear all outputs, counters, req_last, s1 and s2 to 0.
REQ-036 Reset mid-transfer SHALL discard the transfer; no rx_done follows reset release.

Verification
REQ-037 Mode 0 transfer:
  - Stimulus: expected=3, conf=100; 3 toggles with data 0xA, 0xB, 0xC.
  - Response: bp_we at addr 0/1/2 with data A/B/C; pio_ack toggles 3 times; one rx_done pulse; img_we never high.
REQ-038 Back-to-back transfers:
  - Stimulus: mode 0 expected=1, rx_en low 1 cycle, then mode 1 expected=2.
  - Response: one bp_we at 0, then img_we at 0 and 1; two rx_done pulses.
REQ-039 Watchdog expiry:
  - Stimulus: conf=5, expected=2, one toggle only.
  - Response: trigger pulse exactly 6 cycles after WAIT_PKG re-entry; HOLD until rx_en=0; no rx_done.
REQ-040 Stale toggle:
  - Stimulus: toggle pio_req while rx_en=0, then start expected=1.
  - Response: no write until a fresh toggle; pio_ack unchanged by the stale toggle.
REQ-041 Degenerate and abort cases:
  - expected=0 -> rx_done with no strobes.
  - rx_en dropped after 1 of 4 packages -> IDLE, no rx_done, count restarts at 0 on next start.
REQ-042 Reset mid-transfer:
  - Stimulus: assert rst_n=0 during WRITE.
  - Response: all outputs 0 immediately; no strobes or pulses until the next transfer.
